// File: rtl/fifo_pkg.sv
// Shared FIFO-family package: default parameter constants and Gray-code helpers.
// The helpers work on a fixed maximum pointer width (12 address bits plus the
// wrap bit). Callers zero-extend narrower pointers and truncate the result.
// Zero upper bits stay zero under either conversion.
package fifo_pkg;

  localparam int FIFO_ADDRESS_SIZE = 3;
  localparam int FIFO_SYNC_STAGES  = 2;
  localparam int FIFO_AE_LEVEL     = 1;
  localparam int PTR_MAX_W         = 13;

  function automatic logic [PTR_MAX_W-1:0] bin_to_gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray_to_bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock.
// Ports:
//   clk   : destination clock
//   rst_n : async active-low reset, clears every stage
//   d     : Gray pointer from the foreign domain
//   q     : synchronized pointer, STAGES edges behind d
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, memory address, and
// registered empty / almost-empty / level / underflow flags.
// Ports:
//   r_clk, rrst_n   : read clock, async active-low reset
//   r_en            : consumer read request
//   w_ptr           : Gray write pointer from the write domain (async)
//   r_ptr           : registered Gray read pointer to the write domain
//   r_addr          : memory read address (low bits of binary read pointer)
//   r_empty         : registered empty flag
//   r_almost_empty  : registered, fill level <= AE_LEVEL
//   r_level         : registered fill level, 0 .. 2**ADDRESS_SIZE
//   r_underflow     : one-cycle pulse after a read request while empty
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = FIFO_ADDRESS_SIZE,
  parameter int SYNC_STAGES  = FIFO_SYNC_STAGES,
  parameter int AE_LEVEL     = FIFO_AE_LEVEL
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  r_en,
  input  logic [ADDRESS_SIZE:0] w_ptr,
  output logic [ADDRESS_SIZE:0] r_ptr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDRESS_SIZE:0] r_level,
  output logic                  r_underflow
);

  localparam int PW = ADDRESS_SIZE + 1;

  logic [PW-1:0] wq_ptr, wq_bin;
  logic [PW-1:0] r_bin, r_bnext, r_gnext;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wsync (
    .clk  (r_clk),
    .rst_n(rrst_n),
    .d    (w_ptr),
    .q    (wq_ptr)
  );

  // Flags look at the post-read pointer and the current synchronized write
  // pointer together, so a read and a write-pointer change in the same cycle
  // need no arbitration. Modulo arithmetic makes pointer wrap transparent.
  always_comb begin
    rd_ok      = r_en & ~r_empty;
    r_bnext    = r_bin + PW'(rd_ok);
    r_gnext    = PW'(bin_to_gray(PTR_MAX_W'(r_bnext)));
    wq_bin     = PW'(gray_to_bin(PTR_MAX_W'(wq_ptr)));
    level_next = wq_bin - r_bnext;
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= r_bnext;
      r_ptr          <= r_gnext;
      r_empty        <= (r_gnext == wq_ptr);
      r_almost_empty <= (level_next <= PW'(AE_LEVEL));
      r_level        <= level_next;
      r_underflow    <= r_en & r_empty;
    end
  end

  assign r_addr = r_bin[ADDRESS_SIZE-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       r_en = 1'b0;
  logic [3:0] w_ptr = 4'd0;
  logic [3:0] r_ptr, r_level;
  logic [2:0] r_addr;
  logic       r_empty, r_almost_empty, r_underflow;

  logic       r_en4 = 1'b0;
  logic [3:0] w_ptr4 = 4'd0;
  logic [3:0] r_ptr4, r_level4;
  logic [2:0] r_addr4;
  logic       r_empty4, r_almost_empty4, r_underflow4;

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];

  fifo_rd_ctrl #(.ADDRESS_SIZE(3), .SYNC_STAGES(2), .AE_LEVEL(1)) dut (
    .r_clk(clk), .rrst_n(rrst_n), .r_en(r_en), .w_ptr(w_ptr), .r_ptr(r_ptr),
    .r_addr(r_addr), .r_empty(r_empty), .r_almost_empty(r_almost_empty),
    .r_level(r_level), .r_underflow(r_underflow)
  );

  fifo_rd_ctrl #(.ADDRESS_SIZE(3), .SYNC_STAGES(4), .AE_LEVEL(1)) dut4 (
    .r_clk(clk), .rrst_n(rrst_n), .r_en(r_en4), .w_ptr(w_ptr4), .r_ptr(r_ptr4),
    .r_addr(r_addr4), .r_empty(r_empty4), .r_almost_empty(r_almost_empty4),
    .r_level(r_level4), .r_underflow(r_underflow4)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] g4(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(r_empty), 32'd1);
    chk({tag, "_ae"},    32'(r_almost_empty), 32'd1);
    chk({tag, "_level"}, 32'(r_level), 32'd0);
    chk({tag, "_ptr"},   32'(r_ptr), 32'd0);
    chk({tag, "_addr"},  32'(r_addr), 32'd0);
    chk({tag, "_uflow"}, 32'(r_underflow), 32'd0);
  endtask

  initial begin
    int wbin, rbin, wcnt, rcnt, cyc;
    bit seen_gwrap, seen_awrap;
    logic [3:0] prev_ptr;
    logic [2:0] prev_addr;

    // reset state
    tick(); tick();
    chk_reset_vals("rst");
    rrst_n = 1'b1;

    // reads while empty: underflow pulses, pointer frozen
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("uf_pulse", 32'(r_underflow), 32'd1);
      chk("uf_empty", 32'(r_empty), 32'd1);
      chk("uf_addr",  32'(r_addr), 32'd0);
      chk("uf_ptr",   32'(r_ptr), 32'd0);
    end
    r_en = 1'b0;
    tick();
    chk("uf_clear", 32'(r_underflow), 32'd0);

    // one word written: empty falls on the third edge
    exp_addr_q.push_back(0);
    w_ptr = g4(1);
    tick(); chk("w1_e1", 32'(r_empty), 32'd1);
    tick(); chk("w1_e2", 32'(r_empty), 32'd1);
    tick();
    chk("w1_e3",    32'(r_empty), 32'd0);
    chk("w1_level", 32'(r_level), 32'd1);
    chk("w1_ae",    32'(r_almost_empty), 32'd1);
    r_en = 1'b1;
    chk("w1_addr", 32'(r_addr), 32'(exp_addr_q.pop_front()));
    tick();
    r_en = 1'b0;
    chk("w1_rd_empty", 32'(r_empty), 32'd1);
    chk("w1_rd_ptr",   32'(r_ptr), 32'b0001);
    chk("w1_rd_level", 32'(r_level), 32'd0);

    // full FIFO drained by continuous reads
    rrst_n = 1'b0;
    w_ptr = 4'b1100;
    exp_addr_q.delete();
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(i);
    tick(); tick();
    chk("full_still_empty", 32'(r_empty), 32'd1);
    tick();
    chk("full_level", 32'(r_level), 32'd8);
    chk("full_empty", 32'(r_empty), 32'd0);
    chk("full_ae",    32'(r_almost_empty), 32'd0);
    r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", 32'(r_addr), 32'(exp_addr_q.pop_front()));
      tick();
      chk("drain_level", 32'(r_level), 32'(7 - i));
      chk("drain_ae",    32'(r_almost_empty), (7 - i) <= 1 ? 32'd1 : 32'd0);
      chk("drain_empty", 32'(r_empty), i == 7 ? 32'd1 : 32'd0);
    end
    tick();
    chk("drain_uflow", 32'(r_underflow), 32'd1);
    r_en = 1'b0;

    // streaming across pointer wrap
    wbin = 8; rbin = 8; wcnt = 0; rcnt = 0; cyc = 0;
    seen_gwrap = 1'b0; seen_awrap = 1'b0;
    while (rcnt < 20 && cyc < 300) begin
      if (!r_empty) begin
        r_en = 1'b1;
        chk("stream_q_nonempty", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0)
          chk("stream_addr", 32'(r_addr), 32'(exp_addr_q.pop_front()));
      end else begin
        r_en = 1'b0;
      end
      if (wcnt < 20 && (wbin - rbin) < 8) begin
        exp_addr_q.push_back(wbin % 8);
        wbin++; wcnt++;
        w_ptr = g4(wbin);
      end
      prev_ptr = r_ptr;
      prev_addr = r_addr;
      tick();
      cyc++;
      if (r_en) begin
        rbin++; rcnt++;
        chk("stream_rptr", 32'(r_ptr), 32'(g4(rbin)));
        if (prev_ptr == 4'b1000 && r_ptr == 4'b0000) seen_gwrap = 1'b1;
        if (prev_addr == 3'd7 && r_addr == 3'd0) seen_awrap = 1'b1;
      end
      chk("stream_level_max", 32'(r_level <= 4'd8), 32'd1);
    end
    r_en = 1'b0;
    chk("stream_done",  32'(rcnt), 32'd20);
    chk("stream_gwrap", 32'(seen_gwrap), 32'd1);
    chk("stream_awrap", 32'(seen_awrap), 32'd1);
    tick(); tick(); tick();
    chk("stream_end_empty", 32'(r_empty), 32'd1);
    chk("stream_end_level", 32'(r_level), 32'd0);

    // reset mid-read with level 5
    w_ptr = g4(wbin + 5);
    tick(); tick(); tick();
    chk("pre_rst_level", 32'(r_level), 32'd5);
    chk("pre_rst_empty", 32'(r_empty), 32'd0);
    r_en = 1'b1;
    #2;
    rrst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    exp_addr_q.delete();
    w_ptr = g4(3);
    tick();
    chk_reset_vals("held_rst");
    rrst_n = 1'b1;
    r_en = 1'b0;
    for (int i = 0; i < 3; i++) exp_addr_q.push_back(i);
    tick(); chk("post_rst_e1", 32'(r_empty), 32'd1);
    tick(); chk("post_rst_e2", 32'(r_empty), 32'd1);
    tick();
    chk("post_rst_e3",    32'(r_empty), 32'd0);
    chk("post_rst_level", 32'(r_level), 32'd3);
    r_en = 1'b1;
    chk("post_rst_addr0", 32'(r_addr), 32'(exp_addr_q.pop_front()));
    tick();
    r_en = 1'b0;
    chk("post_rst_addr1", 32'(r_addr), 32'(exp_addr_q.pop_front()));
    chk("post_rst_lvl2",  32'(r_level), 32'd2);

    // four-stage synchronizer: empty falls on the fifth edge
    w_ptr4 = g4(1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("sync4_hold", 32'(r_empty4), 32'd1);
    end
    tick();
    chk("sync4_fall",  32'(r_empty4), 32'd0);
    chk("sync4_level", 32'(r_level4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 3, meaning log2 of FIFO depth (depth = 2**ADDRESS_SIZE), legal range 1..12.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flops in the w_ptr synchronizer, legal range 2..4.
REQ-003 SHALL have parameter AE_LEVEL, default 1, meaning almost-empty threshold in words, legal range 0..2**ADDRESS_SIZE-1.
REQ-004 r_clk  input  1  read-domain clock; the only clock.
REQ-005 rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 r_en  input  1  read request from consumer.
REQ-007 w_ptr  input  ADDRESS_SIZE+1  Gray-coded write pointer from write domain, asynchronous to r_clk.
REQ-008 r_ptr  output  ADDRESS_SIZE+1  registered Gray-coded read pointer to write domain.
REQ-009 r_addr  output  ADDRESS_SIZE  memory read address, equal to the low ADDRESS_SIZE bits of the binary read pointer.
REQ-010 r_empty  output  1  registered empty flag.
REQ-011 r_almost_empty  output  1  registered flag, fill level <= AE_LEVEL.
REQ-012 r_level  output  ADDRESS_SIZE+1  registered fill level as seen by the read domain, 0..2**ADDRESS_SIZE.
REQ-013 r_underflow  output  1  one-cycle pulse: read requested while empty.

Function
REQ-014 A read SHALL be accepted in the cycle where r_en=1 and r_empty=0; binary pointer r_bin advances by 1 at that r_clk edge (no r_en delay register).
REQ-015 r_bnext SHALL be r_bin+1 on accepted read, else r_bin; arithmetic modulo 2**(ADDRESS_SIZE+1), wrap from all-ones to 0 with no special case.
REQ-016 r_ptr SHALL be registered bin-to-Gray of r_bnext, so r_ptr always equals Gray(r_bin) one edge after r_bin updates.
REQ-017 w_ptr SHALL pass through SYNC_STAGES flops clocked by r_clk (wq_ptr); w_ptr change is visible to flag logic exactly SYNC_STAGES edges later.
REQ-018 r_empty SHALL be registered (Gray(r_bnext) == wq_ptr); deasserts SYNC_STAGES+1 edges after w_ptr advances from empty, asserts the edge the last word is read.
REQ-019 r_level SHALL be registered (Gray2Bin(wq_ptr) - r_bnext) modulo 2**(ADDRESS_SIZE+1); value 2**ADDRESS_SIZE means full.
REQ-020 r_almost_empty SHALL be registered (level_next <= AE_LEVEL), updated on the same edge as r_level; r_empty=1 implies r_almost_empty=1.
REQ-021 r_underflow SHALL pulse high for exactly the cycle after an edge where r_en=1 and r_empty=1; pointer SHALL NOT move on such a request.
REQ-022 Simultaneous read and write-pointer change SHALL be resolved by using both r_bnext and the current wq_ptr in the same flag computation; no priority needed.
REQ-023 Block SHALL never produce a level > 2**ADDRESS_SIZE given legal write-side behaviour; wrap of either pointer SHALL not disturb level or flags.

Reset
REQ-024 rrst_n low SHALL immediately force r_bin=0, r_ptr=0, r_addr=0, wq_ptr chain=0, r_level=0, r_empty=1, r_almost_empty=1, r_underflow=0.
REQ-025 Reset asserted mid-read SHALL discard the read; first accepted read after release uses r_addr=0.
REQ-026 Flags SHALL remain empty until synchronized w_ptr differs from 0 after reset release.

Structure
REQ-027 bin_to_gray and gray_to_bin functions and default parameter constants SHALL live in shared package fifo_pkg.
REQ-028 Synchronizer SHALL be sub-module gray_sync (parameters WIDTH, STAGES, async active-low reset, ASYNC_REG attribute on all stages).
REQ-029 All other registers SHALL use the async-reset flop style already used in the FIFO family, with reset values per REQ-024.

Verification (ADDRESS_SIZE=3, SYNC_STAGES=2, AE_LEVEL=1)
REQ-030 Reset, w_ptr=0, r_en=1 for 4 cycles -> r_empty=1, r_addr=0, r_underflow pulses each cycle, r_ptr=0.
REQ-031 w_ptr steps Gray 0->1 -> r_empty falls 3 edges later, r_level=1, r_almost_empty=1; one read -> r_empty=1, r_ptr=4'b0001.
REQ-032 w_ptr held at Gray(8) (4'b1100), continuous reads -> r_level 8,7..0, r_almost_empty rises at level 1, r_empty at 0, r_addr 0..7.
REQ-033 Write/read streaming across 20 words -> r_addr wraps 7->0, r_ptr goes through Gray(15)->Gray(0), r_level never exceeds 8, no false empty.
REQ-034 rrst_n pulsed low with level=5 and r_en=1 -> all outputs at REQ-024 values within the same cycle; after release r_addr=0.
REQ-035 SYNC_STAGES=4 rerun of REQ-031 -> r_empty falls 5 edges after w_ptr change.
